// File: rtl/mux_operb.sv
// mux_operb: ALU operand-B select stage.
// Picks the program counter or a numeric operand (register value or immediate)
// under a single select bit, optionally through a one-cycle output register.
//
// Parameters:
//   WIDTH   - data width of pc, input_number and output_Y
//   OUT_REG - 1: output registered (1-cycle latency, sync reset to 0)
//             0: output combinational; clk and reset are unused
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   pc           in   WIDTH  current program counter
//   input_number in   WIDTH  register value or immediate
//   sel_operb    in   1      1 = pc, 0 = input_number
//   output_Y     out  WIDTH  selected operand B
module mux_operb #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] input_number,
    input  logic             sel_operb,
    output logic [WIDTH-1:0] output_Y
);

    // Plain ternary so an X select still propagates in simulation.
    logic [WIDTH-1:0] sel_next_c;
    assign sel_next_c = sel_operb ? pc : input_number;

    generate
        if (OUT_REG) begin : g_reg
            // Reloads every cycle; reset has priority over the selection.
            logic [WIDTH-1:0] y_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    y_q <= '0;
                end else begin
                    y_q <= sel_next_c;
                end
            end

            assign output_Y = y_q;
        end else begin : g_comb
            // No state: clk and reset are intentionally left unconnected.
            logic unused_clk_reset;
            assign unused_clk_reset = ^{clk, reset};

            assign output_Y = sel_next_c;
        end
    endgenerate

endmodule

// File: tb/tb_mux_operb.sv
// tb_mux_operb: directed checks of the registered and combinational variants.
module tb_mux_operb;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] input_number;
    logic             sel_operb;
    logic [WIDTH-1:0] output_Y;

    logic             c_reset;
    logic [WIDTH-1:0] c_pc;
    logic [WIDTH-1:0] c_input_number;
    logic             c_sel_operb;
    logic [WIDTH-1:0] c_output_Y;

    int checks;
    int errors;

    mux_operb #(.WIDTH(WIDTH), .OUT_REG(1'b1)) u_reg (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .input_number (input_number),
        .sel_operb    (sel_operb),
        .output_Y     (output_Y)
    );

    mux_operb #(.WIDTH(WIDTH), .OUT_REG(1'b0)) u_comb (
        .clk          (clk),
        .reset        (c_reset),
        .pc           (c_pc),
        .input_number (c_input_number),
        .sel_operb    (c_sel_operb),
        .output_Y     (c_output_Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        reset          = 1'b1;
        pc             = 32'hFFFF_FFFF;
        input_number   = 32'h1234_5678;
        sel_operb      = 1'b1;
        c_reset        = 1'b0;
        c_pc           = '0;
        c_input_number = '0;
        c_sel_operb    = 1'b0;

        // Reset held for two edges
        step();
        check("reset_edge1", output_Y, 32'h0000_0000);
        step();
        check("reset_edge2", output_Y, 32'h0000_0000);

        // Select pc: still 0 before the edge, all ones after
        reset        = 1'b0;
        pc           = 32'hFFFF_FFFF;
        input_number = 32'h0000_0000;
        sel_operb    = 1'b1;
        #2;
        check("sel_pc_before_edge", output_Y, 32'h0000_0000);
        step();
        check("sel_pc", output_Y, 32'hFFFF_FFFF);

        // Select number
        sel_operb = 1'b0;
        step();
        check("sel_number", output_Y, 32'h0000_0000);

        // Toggle select every cycle
        pc           = 32'hA5A5_A5A5;
        input_number = 32'h5A5A_5A5A;
        sel_operb    = 1'b1;
        step();
        check("toggle_1", output_Y, 32'hA5A5_A5A5);
        sel_operb = 1'b0;
        step();
        check("toggle_2", output_Y, 32'h5A5A_5A5A);
        sel_operb = 1'b1;
        step();
        check("toggle_3", output_Y, 32'hA5A5_A5A5);
        sel_operb = 1'b0;
        step();
        check("toggle_4", output_Y, 32'h5A5A_5A5A);

        // Mid-run reset while streaming pc
        pc        = 32'hDEAD_BEEF;
        sel_operb = 1'b1;
        step();
        check("stream_pc", output_Y, 32'hDEAD_BEEF);
        reset = 1'b1;
        step();
        check("midrun_reset", output_Y, 32'h0000_0000);
        reset = 1'b0;
        step();
        check("reset_recover", output_Y, 32'hDEAD_BEEF);

        // Non-all-ones pattern to catch per-bit faults
        pc           = 32'h0123_4567;
        input_number = 32'h89AB_CDEF;
        sel_operb    = 1'b0;
        step();
        check("pattern_number", output_Y, 32'h89AB_CDEF);
        sel_operb = 1'b1;
        step();
        check("pattern_pc", output_Y, 32'h0123_4567);

        // Combinational variant: follows inputs without an edge, ignores reset
        @(negedge clk);
        c_pc           = 32'hFFFF_FFFF;
        c_input_number = 32'h0000_0000;
        c_sel_operb    = 1'b1;
        #1;
        check("comb_sel_pc", c_output_Y, 32'hFFFF_FFFF);
        c_sel_operb = 1'b0;
        #1;
        check("comb_sel_number", c_output_Y, 32'h0000_0000);
        c_reset     = 1'b1;
        c_sel_operb = 1'b1;
        #1;
        check("comb_reset_ignored", c_output_Y, 32'hFFFF_FFFF);
        step();
        check("comb_reset_after_edge", c_output_Y, 32'hFFFF_FFFF);
        c_pc           = 32'h0F0F_1234;
        c_input_number = 32'hC3C3_5678;
        c_sel_operb    = 1'b0;
        #1;
        check("comb_pattern", c_output_Y, 32'hC3C3_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
